// File: rtl/ahb_modport_slave.sv
`timescale 1ns/1ps
// AHB5 memory-backed slave with pipelined OKAY/ERROR data phases and WAIT_STATES stall cycles.
// Define EXCL_MON_EN to build the per-master exclusive-access monitor.
module ahb_modport_slave #(
  parameter int SLV_ID      = 0,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [15:0] hselx,
  input  logic [31:0] haddr,
  input  logic [2:0]  hburst,
  input  logic        hmastlock,
  input  logic [6:0]  hprot,
  input  logic [2:0]  hsize,
  input  logic        hnonsec,
  input  logic        hexcl,
  input  logic [3:0]  hmaster,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  input  logic        hwrite,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp,
  output logic        hexokay
);
  localparam int          AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0]  WS_C    = 3'(WAIT_STATES);
  localparam logic [31:0] DEPTH_C = 32'(MEM_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t          state_r, state_s;
  logic [2:0]      wcnt_r, wcnt_s;
  logic [AW-1:0]   addr_idx_r;
  logic [1:0]      lane_r, size_r;
  logic            write_r, excl_ok_r;
  logic [31:0]     hrdata_r, hrdata_s;
  logic            hready_r, hready_s, hresp_r, hresp_s, hexokay_r, hexokay_s;
  logic [31:0]     mem_r [MEM_DEPTH];
  logic            accept_s, err_s, complete_s, wr_en_s, excl_new_s, unused_s;
  logic [AW-1:0]   new_idx_s;
  logic [31:0]     wr_word_s, rd_word_s;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [3:0]  be;
    logic [31:0] res;
    case (size)
      2'd0:    be = 4'b0001 << lane;
      2'd1:    be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

  assign hrdata  = hrdata_r;
  assign hready  = hready_r;
  assign hresp   = hresp_r;
  assign hexokay = hexokay_r;

  assign accept_s   = hselx[SLV_ID] & htrans[1] & hready_r;
  assign complete_s = (state_r == ST_DATA);
  assign new_idx_s  = haddr[AW+1:2];
  assign err_s      = (hsize > 3'd2) || ((hsize == 3'd1) && haddr[0]) ||
                      ((hsize == 3'd2) && (haddr[1:0] != 2'd0)) ||
                      ({2'b00, haddr[31:2]} >= DEPTH_C);
  assign wr_word_s  = merge_lanes(mem_r[addr_idx_r], hwdata, size_r, lane_r);
  // A read accepted on the edge that retires a write to the same word sees the new data
  assign rd_word_s  = (wr_en_s && (addr_idx_r == new_idx_s)) ? wr_word_s : mem_r[new_idx_s];

`ifdef EXCL_MON_EN
  logic            excl_r;
  logic [3:0]      master_r;
  logic [15:0]     res_valid_r, res_valid_s;
  logic [AW-1:0]   res_idx_r [16];
  logic [AW-1:0]   res_idx_s [16];

  assign wr_en_s    = complete_s & write_r & (~excl_r | excl_ok_r);
  // Judged against the reservations as they stand after the retiring beat
  assign excl_new_s = hexcl & (~hwrite | (res_valid_s[hmaster] & (res_idx_s[hmaster] == new_idx_s)));
  assign unused_s   = ^{hburst, hmastlock, hprot, hnonsec, hselx};

  // Reservation updates caused by the beat retiring this cycle
  always_comb begin
    res_valid_s = res_valid_r;
    res_idx_s   = res_idx_r;
    if (wr_en_s) begin
      for (int i = 0; i < 16; i++) begin
        if (res_idx_r[i] == addr_idx_r) res_valid_s[i] = 1'b0;
        else                            res_valid_s[i] = res_valid_r[i];
      end
    end else if (complete_s && !write_r && excl_r) begin
      res_valid_s[master_r] = 1'b1;
      res_idx_s[master_r]   = addr_idx_r;
    end else begin
      res_valid_s = res_valid_r;
    end
  end

  // Exclusive qualifiers of the accepted beat and the reservation table
  always_ff @(posedge hclk or posedge hresetn) begin
    if (hresetn) begin
      excl_r      <= 1'b0;
      master_r    <= 4'd0;
      res_valid_r <= 16'h0000;
      for (int i = 0; i < 16; i++) res_idx_r[i] <= {AW{1'b0}};
    end else begin
      if (accept_s) begin
        excl_r   <= hexcl;
        master_r <= hmaster;
      end
      res_valid_r <= res_valid_s;
      res_idx_r   <= res_idx_s;
    end
  end
`else
  assign wr_en_s    = complete_s & write_r;
  assign excl_new_s = 1'b0;
  assign unused_s   = ^{hburst, hmastlock, hprot, hnonsec, hselx, hexcl, hmaster};
`endif

  // Next state and next registered bus outputs
  always_comb begin
    state_s   = ST_IDLE;
    wcnt_s    = wcnt_r;
    hready_s  = 1'b1;
    hresp_s   = 1'b0;
    hrdata_s  = 32'h0000_0000;
    hexokay_s = 1'b0;
    case (state_r)
      ST_WAIT: begin
        hrdata_s = hrdata_r;
        if (wcnt_r == 3'd0) begin
          state_s   = ST_DATA;
          hexokay_s = excl_ok_r;
        end else begin
          state_s  = ST_WAIT;
          wcnt_s   = wcnt_r - 3'd1;
          hready_s = 1'b0;
        end
      end
      ST_ERR1: begin
        state_s = ST_ERR2;
        hresp_s = 1'b1;
      end
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept_s && err_s) begin
          state_s  = ST_ERR1;
          hready_s = 1'b0;
          hresp_s  = 1'b1;
        end else if (accept_s) begin
          hrdata_s = hwrite ? 32'h0000_0000 : rd_word_s;
          if (WS_C == 3'd0) begin
            state_s   = ST_DATA;
            hexokay_s = excl_new_s;
          end else begin
            state_s  = ST_WAIT;
            wcnt_s   = WS_C - 3'd1;
            hready_s = 1'b0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge hclk or posedge hresetn) begin
    if (hresetn) begin
      state_r   <= ST_IDLE;
      wcnt_r    <= 3'd0;
      hready_r  <= 1'b1;
      hresp_r   <= 1'b0;
      hrdata_r  <= 32'h0000_0000;
      hexokay_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      wcnt_r    <= wcnt_s;
      hready_r  <= hready_s;
      hresp_r   <= hresp_s;
      hrdata_r  <= hrdata_s;
      hexokay_r <= hexokay_s;
    end
  end

  // Address-phase capture for the beat now entering its data phase
  always_ff @(posedge hclk or posedge hresetn) begin
    if (hresetn) begin
      addr_idx_r <= {AW{1'b0}};
      lane_r     <= 2'd0;
      size_r     <= 2'd0;
      write_r    <= 1'b0;
      excl_ok_r  <= 1'b0;
    end else if (accept_s) begin
      addr_idx_r <= new_idx_s;
      lane_r     <= haddr[1:0];
      size_r     <= hsize[1:0];
      write_r    <= hwrite;
      excl_ok_r  <= excl_new_s;
    end
  end

  // Storage is not reset; a write lands only on the edge that retires its data phase
  always_ff @(posedge hclk) begin
    if (wr_en_s) mem_r[addr_idx_r] <= wr_word_s;
  end
endmodule

// File: tb/tb_ahb_modport_slave.sv
`timescale 1ns/1ps
// Directed bench: two slaves (WAIT_STATES 0 and 2) on one bus, checked every cycle against
// a byte-level memory/reservation model that schedules expected responses per cycle.
module tb_ahb_modport_slave;
  logic        hclk = 1'b0;
  logic        hresetn;
  logic [15:0] hselx;
  logic [31:0] haddr, hwdata;
  logic [2:0]  hburst, hsize;
  logic        hmastlock, hnonsec, hexcl, hwrite;
  logic [6:0]  hprot;
  logic [3:0]  hmaster;
  logic [1:0]  htrans;
  logic [31:0] rdata0, rdata1;
  logic        ready0, ready1, resp0, resp1, exok0, exok1;

`ifdef EXCL_MON_EN
  localparam bit EXCL = 1'b1;
`else
  localparam bit EXCL = 1'b0;
`endif

  ahb_modport_slave #(.SLV_ID(0), .MEM_DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hresetn(hresetn), .hselx(hselx), .haddr(haddr), .hburst(hburst),
    .hmastlock(hmastlock), .hprot(hprot), .hsize(hsize), .hnonsec(hnonsec), .hexcl(hexcl),
    .hmaster(hmaster), .htrans(htrans), .hwdata(hwdata), .hwrite(hwrite),
    .hrdata(rdata0), .hready(ready0), .hresp(resp0), .hexokay(exok0));

  ahb_modport_slave #(.SLV_ID(1), .MEM_DEPTH(1024), .WAIT_STATES(2)) u_ws2 (
    .hclk(hclk), .hresetn(hresetn), .hselx(hselx), .haddr(haddr), .hburst(hburst),
    .hmastlock(hmastlock), .hprot(hprot), .hsize(hsize), .hnonsec(hnonsec), .hexcl(hexcl),
    .hmaster(hmaster), .htrans(htrans), .hwdata(hwdata), .hwrite(hwrite),
    .hrdata(rdata1), .hready(ready1), .hresp(resp1), .hexokay(exok1));

  always #5 hclk = ~hclk;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  bit          chk_en = 1'b0;
  logic [34:0] exp_tab [int];
  logic [7:0]  bmem [int];
  bit          res_v [2][16];
  int          res_i [2][16];
  logic [34:0] e_v, a_v;

  always @(posedge hclk) cyc <= cyc + 1;

  // Per-cycle compare of both slaves against the scheduled model responses
  always @(negedge hclk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        e_v = exp_tab.exists(cyc*2 + k) ? exp_tab[cyc*2 + k] : {1'b1, 1'b0, 1'b0, 32'h0};
        a_v = (k == 0) ? {ready0, resp0, exok0, rdata0} : {ready1, resp1, exok1, rdata1};
        total++;
        if (a_v !== e_v) begin
          bad++;
          $display("FAIL cycle_check slave%0d cyc=%0d got rdy/resp/exok/rdata=%b/%b/%b/%h want %b/%b/%b/%h",
                   k, cyc, a_v[34], a_v[33], a_v[32], a_v[31:0], e_v[34], e_v[33], e_v[32], e_v[31:0]);
        end
      end
    end
  end

  function automatic int bkey(int k, int a);
    return k * 32'h0001_0000 + a;
  endfunction

  function automatic logic [31:0] mword(int k, int idx);
    logic [31:0] w;
    for (int b = 0; b < 4; b++)
      w[8*b +: 8] = bmem.exists(bkey(k, idx*4 + b)) ? bmem[bkey(k, idx*4 + b)] : 8'h00;
    return w;
  endfunction

  task automatic sched(input int k, input int c, input logic r, input logic e, input logic x,
                       input logic [31:0] d);
    exp_tab[c*2 + k] = {r, e, x, d};
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic clear_res();
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 16; j++) res_v[k][j] = 1'b0;
  endtask

  // One beat: address phase now, returns 1ns into the last data-phase cycle
  task automatic xfer(input int k, input logic [31:0] a, input logic [2:0] sz, input logic wr,
                      input logic [31:0] wd, input logic [1:0] tr, input logic ex,
                      input logic [3:0] m);
    int ws, idx, nb, c0, ai, n;
    bit err, ok_ex, do_wr;
    logic [31:0] rd;
    hselx = 16'h0001 << k; haddr = a; hsize = sz; hwrite = wr; htrans = tr;
    hexcl = ex; hmaster = m;
    @(posedge hclk); #1;
    hwdata = wd;
    c0  = cyc;
    ws  = (k == 0) ? 0 : 2;
    ai  = int'(a);
    idx = ai / 4;
    nb  = 1 << sz;
    err = (sz > 3'd2) || ((ai % nb) != 0) || (idx >= 1024);
    if (err) begin
      sched(k, c0, 1'b0, 1'b1, 1'b0, 32'h0);
      sched(k, c0 + 1, 1'b1, 1'b1, 1'b0, 32'h0);
    end else begin
      ok_ex = EXCL && ex && (!wr || (res_v[k][m] && res_i[k][m] == idx));
      do_wr = wr && (!(EXCL && ex) || ok_ex);
      rd = wr ? 32'h0 : mword(k, idx);
      for (int i = 0; i < ws; i++) sched(k, c0 + i, 1'b0, 1'b0, 1'b0, rd);
      sched(k, c0 + ws, 1'b1, 1'b0, ok_ex, rd);
      if (do_wr) begin
        for (int b = 0; b < nb; b++) bmem[bkey(k, ai + b)] = wd[8*((ai + b) % 4) +: 8];
        for (int j = 0; j < 16; j++) if (res_i[k][j] == idx) res_v[k][j] = 1'b0;
      end
      if (EXCL && ex && !wr) begin
        res_v[k][m] = 1'b1;
        res_i[k][m] = idx;
      end
    end
    n = err ? 2 : ws + 1;
    repeat (n - 1) begin @(posedge hclk); #1; end
    htrans = 2'b00; hselx = 16'h0000; hexcl = 1'b0;
  endtask

  task automatic idle(input int n);
    htrans = 2'b00; hselx = 16'h0000; hexcl = 1'b0;
    repeat (n) begin @(posedge hclk); #1; end
  endtask

  initial begin
    hresetn = 1'b0; hselx = 16'h0; haddr = 32'h0; hburst = 3'd0; hmastlock = 1'b0;
    hprot = 7'h0; hsize = 3'd0; hnonsec = 1'b0; hexcl = 1'b0; hmaster = 4'd0;
    htrans = 2'b00; hwdata = 32'h0; hwrite = 1'b0;
    clear_res();
    #2 hresetn = 1'b1;
    #1;
    chk("rst_hready0", {31'h0, ready0}, 32'h1);
    chk("rst_hresp0",  {31'h0, resp0},  32'h0);
    chk("rst_hrdata0", rdata0, 32'h0);
    chk("rst_hexokay0", {31'h0, exok0}, 32'h0);
    chk("rst_hready1", {31'h0, ready1}, 32'h1);
    chk("rst_hrdata1", rdata1, 32'h0);
    chk_en = 1'b1;
    repeat (2) @(posedge hclk);
    @(negedge hclk) hresetn = 1'b0;
    @(posedge hclk); #1;

    // word write then pipelined read-back
    xfer(0, 32'h10, 3'd2, 1'b1, 32'hDEADBEEF, 2'b10, 1'b0, 4'd0);
    xfer(0, 32'h10, 3'd2, 1'b0, 32'h0, 2'b10, 1'b0, 4'd0);
    chk("rd_deadbeef", rdata0, 32'hDEADBEEF);
    chk("rd_ready", {30'h0, ready0, resp0}, 32'h2);
    // byte and halfword lanes
    xfer(0, 32'h10, 3'd2, 1'b1, 32'h11223344, 2'b10, 1'b0, 4'd0);
    xfer(0, 32'h13, 3'd0, 1'b1, 32'hAA000000, 2'b10, 1'b0, 4'd0);
    xfer(0, 32'h10, 3'd2, 1'b0, 32'h0, 2'b10, 1'b0, 4'd0);
    chk("rd_byte", rdata0, 32'hAA223344);
    xfer(0, 32'h12, 3'd1, 1'b1, 32'hBEEF5A5A, 2'b10, 1'b0, 4'd0);
    xfer(0, 32'h10, 3'd2, 1'b0, 32'h0, 2'b10, 1'b0, 4'd0);
    chk("rd_half", rdata0, 32'hBEEF3344);
    xfer(0, 32'h11, 3'd0, 1'b1, 32'h00007700, 2'b10, 1'b0, 4'd0);
    xfer(0, 32'h10, 3'd2, 1'b0, 32'h0, 2'b10, 1'b0, 4'd0);
    chk("rd_byte1", rdata0, 32'hBEEF7744);
    idle(1);
    // error responses
    xfer(0, 32'h02, 3'd2, 1'b0, 32'h0, 2'b10, 1'b0, 4'd0);
    chk("err_misalign", {30'h0, ready0, resp0}, 32'h3);
    xfer(0, 32'h00, 3'd2, 1'b1, 32'h01234567, 2'b10, 1'b0, 4'd0);
    xfer(0, 32'h1000, 3'd2, 1'b1, 32'hFFFFFFFF, 2'b10, 1'b0, 4'd0);
    xfer(0, 32'h00, 3'd2, 1'b0, 32'h0, 2'b10, 1'b0, 4'd0);
    chk("err_nowrite", rdata0, 32'h01234567);
    xfer(0, 32'h18, 3'd3, 1'b0, 32'h0, 2'b10, 1'b0, 4'd0);
    xfer(0, 32'h11, 3'd1, 1'b1, 32'h0, 2'b10, 1'b0, 4'd0);
    xfer(0, 32'hFFC, 3'd2, 1'b1, 32'h9ABCDEF0, 2'b10, 1'b0, 4'd0);
    xfer(0, 32'hFFC, 3'd2, 1'b0, 32'h0, 2'b10, 1'b0, 4'd0);
    chk("rd_lastword", rdata0, 32'h9ABCDEF0);
    idle(2);

    // wait-state slave: fill then 4-beat INCR burst
    for (int i = 0; i < 4; i++)
      xfer(1, 32'h20 + 4*i, 3'd2, 1'b1, 32'hC0DE0000 + i, 2'b10, 1'b0, 4'd0);
    hburst = 3'b001;
    for (int i = 0; i < 4; i++) begin
      xfer(1, 32'h20 + 4*i, 3'd2, 1'b0, 32'h0, (i == 0) ? 2'b10 : 2'b11, 1'b0, 4'd0);
      chk("burst_data", rdata1, 32'hC0DE0000 + i);
    end
    hburst = 3'b000;
    idle(1);
    // nobody selected: no response and no write
    hselx = 16'h0020; haddr = 32'h10; hsize = 3'd2; hwrite = 1'b1; htrans = 2'b10;
    repeat (3) begin @(posedge hclk); #1; end
    hwdata = 32'hFFFFFFFF;
    chk("unsel_ready", {30'h0, ready0, ready1}, 32'h3);
    idle(1);
    xfer(0, 32'h10, 3'd2, 1'b0, 32'h0, 2'b10, 1'b0, 4'd0);
    chk("unsel_nowrite", rdata0, 32'hBEEF7744);
    idle(1);

    // reset during the wait state of a write
    xfer(1, 32'h40, 3'd2, 1'b1, 32'hCAFEF00D, 2'b10, 1'b0, 4'd0);
    idle(1);
    hselx = 16'h0002; haddr = 32'h40; hsize = 3'd2; hwrite = 1'b1; htrans = 2'b10;
    @(posedge hclk); #1;
    hwdata = 32'h12345678; htrans = 2'b00; hselx = 16'h0000;
    hresetn = 1'b1;
    clear_res();
    #1;
    chk("abort_ready_resp", {30'h0, ready1, resp1}, 32'h2);
    @(posedge hclk); #1;
    hresetn = 1'b0;
    xfer(1, 32'h40, 3'd2, 1'b0, 32'h0, 2'b10, 1'b0, 4'd0);
    chk("abort_oldval", rdata1, 32'hCAFEF00D);
    idle(1);

    // exclusive sequence on the zero-wait slave
    xfer(0, 32'h80, 3'd2, 1'b1, 32'h0, 2'b10, 1'b0, 4'd3);
    xfer(0, 32'h80, 3'd2, 1'b0, 32'h0, 2'b10, 1'b1, 4'd3);
    chk("ex_rd_okay", {31'h0, exok0}, {31'h0, EXCL});
    xfer(0, 32'h80, 3'd2, 1'b1, 32'h55, 2'b10, 1'b1, 4'd3);
    chk("ex_wr_okay", {31'h0, exok0}, {31'h0, EXCL});
    xfer(0, 32'h80, 3'd2, 1'b0, 32'h0, 2'b10, 1'b0, 4'd3);
    chk("ex_mem55", rdata0, 32'h00000055);
    xfer(0, 32'h80, 3'd2, 1'b0, 32'h0, 2'b10, 1'b1, 4'd3);
    xfer(0, 32'h82, 3'd1, 1'b1, 32'h0, 2'b10, 1'b1, 4'd3);
    xfer(0, 32'h80, 3'd2, 1'b1, 32'h66, 2'b10, 1'b0, 4'd5);
    xfer(0, 32'h80, 3'd2, 1'b1, 32'h77, 2'b10, 1'b1, 4'd3);
    chk("ex_wr_fail", {31'h0, exok0}, 32'h0);
    xfer(0, 32'h80, 3'd2, 1'b0, 32'h0, 2'b10, 1'b0, 4'd3);
    chk("ex_mem_after", rdata0, EXCL ? 32'h00000066 : 32'h00000077);
    idle(3);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ahb_modport_slave.md
Name: ahb_modport_slave

Overview:
AHB5 memory-backed slave attached to the `ahb_interface` signal set. It sits behind the master/driver side of the bus.
- Decodes its own select bit from `hselx`.
- Services single and burst beats with a configurable number of wait states.
- Returns OKAY or two-cycle ERROR responses.
- Optionally tracks exclusive accesses.

Parameters:
- SLV_ID, 0: index into `hselx` that selects this slave (0..15).
- MEM_DEPTH, 1024: number of 32-bit words of storage. Must be a power of 2.
- WAIT_STATES, 0: cycles with `hready` low inserted at the start of every OKAY data phase (0..7).

Ports:
- hclk  in  1  bus clock; all state updates on the rising edge.
- hresetn  in  1  asynchronous, active-high reset (asserted = 1).
- hselx  in  16  slave selects; only bit SLV_ID is used.
- haddr  in  32  byte address.
- hburst  in  3  burst type; accepted, no effect (each beat carries its own address).
- hmastlock  in  1  accepted, no effect.
- hprot  in  7  accepted, no effect.
- hsize  in  3  transfer size.
- hnonsec  in  1  accepted, no effect.
- hexcl  in  1  exclusive-access qualifier.
- hmaster  in  4  master ID.
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwdata  in  32  write data, valid in the data phase.
- hwrite  in  1  1=write, 0=read.
- hrdata  out  32  read data.
- hready  out  1  transfer-complete / slave ready.
- hresp  out  1  0=OKAY, 1=ERROR.
- hexokay  out  1  exclusive success.

Behaviour:
- Reset (`hresetn`=1): `hready`=1, `hresp`=0, `hrdata`=0, `hexokay`=0. Any pending data phase is aborted and a pending write is dropped. Memory contents are retained (not cleared).
- Address phase is accepted on a rising edge when `hselx[SLV_ID]`=1, `htrans[1]`=1 and `hready`=1. On acceptance, latch `haddr`, `hsize`, `hwrite`, `hexcl`, `hmaster`.
- IDLE/BUSY, or not selected: no data phase. Outputs stay at `hready`=1, `hresp`=0, `hexokay`=0.
- Error check, evaluated at acceptance. Any of the following gives an ERROR response:
  - `hsize` > 2;
  - misalignment (halfword with `haddr[0]`=1; word with `haddr[1:0]`≠0);
  - word index `haddr[31:2]` ≥ MEM_DEPTH.
- ERROR response: first cycle `hready`=0, `hresp`=1; second cycle `hready`=1, `hresp`=1. No memory write is performed. WAIT_STATES does not apply to errors.
- OKAY data phase: WAIT_STATES cycles with `hready`=0, `hresp`=0, then one cycle with `hready`=1. A new address phase is accepted only on the edge that ends the `hready`=1 cycle, so back-to-back transfers are pipelined.
- Write: on the completing edge, write `hwdata` byte lanes selected by `hsize`/`haddr[1:0]` (little-endian). Bytes: lane `haddr[1:0]`. Halfwords: lanes 0–1 or 2–3. Word: all lanes. Other bytes are unchanged.
- Read: `hrdata` = full stored word at the latched word index during the whole read data phase, and is 0 at all other times. A read whose data phase follows a write to the same word returns the newly written data.
- `hburst` wrap/increment is not checked; every beat is an independent access.

Optional Feature:
- Macro EXCL_MON_EN.
- Defined: one reservation register (valid + word index) per `hmaster` value (16 entries).
  - Exclusive read (`hexcl`=1) with OKAY response sets that master's reservation to the accessed word and drives `hexokay`=1 in the completing cycle.
  - Exclusive write succeeds when the master's reservation is valid and matches the word: memory is written, `hexokay`=1 and the reservation is cleared.
  - Exclusive write otherwise fails: no memory write, `hresp`=OKAY, `hexokay`=0.
  - Any successful write, by any master, clears every reservation on that word.
  - Errored exclusives give `hexokay`=0 and leave reservations unchanged.
  - Reset clears all reservations.
- Undefined: `hexcl` is ignored, `hexokay` is tied to 0, and exclusive writes behave as normal writes.

Test Plan:
- Reset with outputs checked, then write word 0xDEADBEEF to 0x10 (NONSEQ, hsize=2) and read 0x10 back → `hrdata`=0xDEADBEEF, `hresp`=0, `hready`=1 in each data phase (WAIT_STATES=0).
- Byte write 0xAA to 0x13 over stored 0x11223344, then word read of 0x10 → 0xAA223344.
- Misaligned word read at 0x02 → cycle 1 `hready`=0/`hresp`=1, cycle 2 `hready`=1/`hresp`=1. Write to 0x1000 with MEM_DEPTH=1024 → same ERROR, memory unchanged.
- WAIT_STATES=2, 4-beat INCR read 0x20..0x2C with SEQ beats → each beat shows 2 `hready`-low cycles, then data from sequential words; `hselx`≠bit SLV_ID → no response, `hready` stays 1.
- Reset asserted during the wait state of a write to 0x40 → `hready`=1, `hresp`=0 immediately; a later read of 0x40 returns the old value.
- EXCL_MON_EN defined:
  - master 3 exclusive-reads 0x80 → `hexokay`=1;
  - master 3 exclusive-writes 0x55 to 0x80 → `hexokay`=1, memory=0x55;
  - after master 5 performs a normal write to 0x80, a second master-3 exclusive write fails → `hexokay`=0, memory unchanged.
